// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the RS latch driver.
// Holds the FSM state enum, error codes and a sizing helper.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    PULSE,
    CHECK,
    REPORT
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_INVALID = 2'b11;

  localparam int SYNC_DEPTH = 2;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for asynchronous latch feedback.
// Ports: clk, rst (async high), d (async in), q (synced out).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R of an external RS latch from set/reset commands.
// Ports: cmd handshake in, S/R out, Q/QB feedback in, done/err/q_state out.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int DEAD_W  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  input  logic       cmd_rst,
  output logic       cmd_ready,
  output logic       S,
  output logic       R,
  input  logic       q_fb,
  input  logic       qb_fb,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       q_state
);

  // Counter must also reach the settle point in CHECK.
  localparam int CNT_MAX = max_of(
    max_of(PULSE_W, DEAD_W),
    max_of(TIMEOUT, SYNC_DEPTH));
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam int TO_LAST =
    max_of(TIMEOUT - 1, SYNC_DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            target_q, target_d;
  logic            inv_q, inv_d;
  logic            q_s, qb_s;
  logic            s_d, r_d;
  logic            done_d, err_d;
  logic [1:0]      code_d;
  logic            q_state_d;
  logic            settled, ok, bad;

  sync2 u_sync_q (
    .clk (clk),
    .rst (rst),
    .d   (q_fb),
    .q   (q_s)
  );

  sync2 u_sync_qb (
    .clk (clk),
    .rst (rst),
    .d   (qb_fb),
    .q   (qb_s)
  );

  assign cmd_ready = (state_q == IDLE);

  // Feedback is judged only once the synchronizer holds
  // values sampled after S/R were released.
  assign settled = (cnt_q >= CW'(SYNC_DEPTH));
  assign ok  = settled
             && (q_s == target_q)
             && (qb_s == ~target_q);
  assign bad = settled && (q_s == qb_s);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    target_d  = target_q;
    inv_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
    q_state_d = q_state;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          unique case (1'b1)
            (cmd_set & ~cmd_rst): begin
              target_d = 1'b1;
              state_d  = DEAD;
            end
            (cmd_rst & ~cmd_set): begin
              target_d = 1'b0;
              state_d  = DEAD;
            end
            default: begin
              state_d = REPORT;
              err_d   = 1'b1;
              code_d  = ERR_ILLEGAL;
            end
          endcase
        end
      end
      DEAD: begin
        if (cnt_q == CW'(DEAD_W - 1)) begin
          state_d = PULSE;
          cnt_d   = '0;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(PULSE_W - 1)) begin
          state_d = CHECK;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        inv_d = bad;
        if (ok) begin
          state_d   = REPORT;
          done_d    = 1'b1;
          q_state_d = target_q;
        end else if (bad && inv_q) begin
          state_d = REPORT;
          err_d   = 1'b1;
          code_d  = ERR_INVALID;
        end else if (cnt_q == CW'(TO_LAST)) begin
          state_d = REPORT;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      REPORT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    s_d = (state_d == PULSE) &&  target_d;
    r_d = (state_d == PULSE) && !target_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= 1'b0;
      inv_q    <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      q_state  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      inv_q    <= inv_d;
      S        <= s_d;
      R        <= r_d;
      done     <= done_d;
      err      <= err_d;
      err_code <= code_d;
      q_state  <= q_state_d;
    end
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous controller that drives the S/R inputs of an external RS latch (the NOR or NAND latch cells under test) and reads its Q/QB outputs back.
- Accepts set/reset commands over a valid/ready handshake and never drives S=R=1.
- Generates a fixed-width pulse preceded by a dead gap, then confirms the latch state from synchronized feedback and reports done or error.
- Sits between lab control logic and latch cells so the stimulus sequences now written by hand in benches come from hardware.

Parameters:
- PULSE_W, 4, cycles S or R is held high per command (>=1).
- DEAD_W, 1, cycles both S and R are held low before each pulse (>=1).
- TIMEOUT, 16, max cycles to wait for Q/QB to match after the pulse ends (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_set  in  1  request Q=1.
- cmd_rst  in  1  request Q=0.
- cmd_ready  out  1  driver idle and able to accept.
- S  out  1  latch set drive.
- R  out  1  latch reset drive.
- q_fb  in  1  latch Q, asynchronous to clk.
- qb_fb  in  1  latch QB, asynchronous to clk.
- done  out  1  one-cycle pulse: command completed, latch confirmed.
- err  out  1  one-cycle pulse: command rejected or verification failed.
- err_code  out  2  valid with err: 01 illegal cmd, 10 timeout, 11 invalid feedback (Q==QB).
- q_state  out  1  last confirmed latch state.

Behaviour:
- Reset (async, any state): S=0, R=0, done=0, err=0, err_code=00, q_state=0, cmd_ready=1, FSM=IDLE, counters=0, sync flops=0.
- q_fb/qb_fb pass through a 2-flop synchronizer each. Only the synced values are used.
- FSM states: IDLE, DEAD, PULSE, CHECK, REPORT.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid&cmd_ready. Latch the target: 1 for set, 0 for reset.
  - cmd_set=cmd_rst=1, or both 0, with valid: no pulse; REPORT next cycle with err=1, code 01.
  - Legal command goes to DEAD; cmd_ready drops the cycle after acceptance.
- DEAD: S=R=0 for exactly DEAD_W cycles, then PULSE.
- PULSE:
  - Drive S=1 (target 1) or R=1 (target 0) for exactly PULSE_W cycles.
  - The opposite line stays 0.
  - S and R are registered outputs and never both 1.
- CHECK:
  - S=R=0. Count cycles from 0.
  - Success when synced q=target and qb=~target: REPORT with done=1, q_state=target.
  - Synced q==qb for 2 consecutive cycles: REPORT with err, code 11.
  - Count reaches TIMEOUT without success: REPORT with err, code 10.
  - Success checked first in the same cycle as timeout.
- REPORT:
  - Exactly one cycle; done or err is high (mutually exclusive).
  - Return to IDLE; cmd_ready=1 the following cycle.
- Latency, legal command with fast feedback: done asserts DEAD_W+PULSE_W+3 cycles after the accept edge (2 sync + 1 check), +1 REPORT register.
- cmd_valid while busy is ignored (not queued). The requester holds it until ready.
- q_state updates only on done. It is unchanged on err.
- Asserting rst mid-pulse forces S=R=0 immediately (async).
- Counters are sized $clog2(max(PULSE_W,DEAD_W,TIMEOUT)+1) bits and saturate-free since they reset at each state entry.

Decomposition:
- Package sr_drv_pkg: state enum (IDLE, DEAD, PULSE, CHECK, REPORT) and err_code localparams ERR_NONE=2'b00, ERR_ILLEGAL=2'b01, ERR_TIMEOUT=2'b10, ERR_INVALID=2'b11.
- Sub-module sync2: 2-flop synchronizer with async active-high reset to 0, instantiated for q_fb and qb_fb.

Test Plan:
- Reset then set cmd, latch model answers in 1 cycle: S high exactly 4 cycles after 1 dead cycle; done at the expected cycle; q_state=1; R stays 0 throughout.
- Reset cmd after set: R pulse of 4 cycles; done; q_state=0; S never 1.
- cmd_set=cmd_rst=1 with valid: S=R=0 all the time; err=1, err_code=01 next cycle; q_state unchanged.
- Latch model stuck (q_fb=0, qb_fb=1) on set: err_code=10 after 16 check cycles; q_state stays 0.
- Model forces q_fb=qb_fb=0 after pulse: err_code=11 within 2 synced cycles.
- Assert rst during the 2nd PULSE cycle: S drops to 0 the same time step; cmd_ready=1; the next set cmd completes normally.
